// File: rtl/z80_sys_pkg.sv
// Shared definitions for the Z80 system bus blocks: arbiter state encoding,
// default timing parameters and small arithmetic helpers.
package z80_sys_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GRANT = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    localparam int unsigned DEF_WAIT_STATES = 1;
    localparam int unsigned DEF_REQ_TIMEOUT = 255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dma_wait_gen.sv
// Wait-state generator: a qualified rising strobe loads LOAD_VALUE into a
// down-counter; ready is low while the count is nonzero.
module dma_wait_gen #(
    parameter int unsigned LOAD_VALUE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cen,
    input  logic strobe,
    input  logic inhibit,
    output logic ready,
    output logic done,
    output logic idle
);

    localparam logic [3:0] LOAD_CNT = LOAD_VALUE[3:0];

    logic [3:0] cnt_r;
    logic [3:0] cnt_next_s;
    logic       strobe_prev_r;
    logic       ready_r;
    logic       load_s;
    logic       done_s;

    // Next count: an active count runs down before a new strobe may reload it.
    always_comb begin
        cnt_next_s = cnt_r;
        done_s     = 1'b0;
        load_s     = strobe & ~strobe_prev_r & ~inhibit & (cnt_r == 4'd0);
        if (cnt_r != 4'd0) begin
            cnt_next_s = cnt_r - 4'd1;
            done_s     = (cnt_r == 4'd1);
        end else if (load_s) begin
            cnt_next_s = LOAD_CNT;
            done_s     = (LOAD_CNT == 4'd0);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter, edge-detect history and registered ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r         <= 4'd0;
            strobe_prev_r <= 1'b0;
            ready_r       <= 1'b1;
        end else if (cen) begin
            cnt_r         <= cnt_next_s;
            strobe_prev_r <= strobe;
            ready_r       <= (cnt_next_s == 4'd0);
        end
    end

    assign ready = ready_r;
    assign done  = done_s & cen;
    assign idle  = (cnt_r == 4'd0);

endmodule

// File: rtl/dma_bus_arbiter.sv
// Arbitrates the shared memory port between the Z80 CPU and a DMA master
// using the Z80 BUSREQ/BUSACK handshake, with wait states and a request timeout.
module dma_bus_arbiter
    import z80_sys_pkg::*;
#(
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
    parameter int unsigned REQ_TIMEOUT = DEF_REQ_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        dma_busrq,
    output logic        dma_busack,
    output logic        dma_ready,
    input  logic        dma_memr,
    input  logic        dma_memw,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic [7:0]  dma_rdata,
    output logic        cpu_busrq_n,
    input  logic        cpu_busack_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [7:0]  mem_rdata,
    output logic        dma_owner,
    output logic        timeout_err
);

    localparam logic [7:0] TIMEOUT_CNT = REQ_TIMEOUT[7:0];

    arb_state_e state_r;
    arb_state_e state_next_s;
    logic       busrq_n_r;
    logic       busrq_n_next_s;
    logic       busack_r;
    logic       busack_next_s;
    logic       owner_r;
    logic       owner_next_s;
    logic       err_r;
    logic       err_next_s;
    logic [7:0] req_cnt_r;
    logic [7:0] req_cnt_next_s;
    logic [7:0] rdata_r;
    logic       both_s;
    logic       wait_strobe_s;
    logic       wait_ready_s;
    logic       wait_done_s;
    logic       wait_idle_s;

    assign both_s        = dma_memr & dma_memw;
    assign wait_strobe_s = (state_r == ST_GRANT) & (dma_memr | dma_memw);

    dma_wait_gen #(
        .LOAD_VALUE (WAIT_STATES)
    ) u_wait_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .strobe  (wait_strobe_s),
        .inhibit (both_s),
        .ready   (wait_ready_s),
        .done    (wait_done_s),
        .idle    (wait_idle_s)
    );

    // Next-state and next-output logic of the bus handshake FSM.
    always_comb begin
        state_next_s   = state_r;
        busrq_n_next_s = busrq_n_r;
        busack_next_s  = busack_r;
        err_next_s     = err_r;
        req_cnt_next_s = 8'd0;
        case (state_r)
            ST_IDLE: begin
                if (dma_busrq) begin
                    state_next_s   = ST_REQ;
                    busrq_n_next_s = 1'b0;
                    err_next_s     = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!cpu_busack_n) begin
                    state_next_s  = ST_GRANT;
                    busack_next_s = 1'b1;
                end else if (!dma_busrq) begin
                    state_next_s   = ST_IDLE;
                    busrq_n_next_s = 1'b1;
                end else begin
                    req_cnt_next_s = sat_inc8(req_cnt_r);
                    if (req_cnt_next_s >= TIMEOUT_CNT) begin
                        err_next_s = 1'b1;
                    end else begin
                        err_next_s = err_r;
                    end
                end
            end
            ST_GRANT: begin
                if (!dma_busrq) begin
                    state_next_s  = ST_DRAIN;
                    busack_next_s = 1'b0;
                end else begin
                    state_next_s = ST_GRANT;
                end
            end
            ST_DRAIN: begin
                // Hold the bus until the DMA strobe and any pending wait states finish.
                if (!dma_memr && !dma_memw && wait_idle_s) begin
                    state_next_s   = ST_IDLE;
                    busrq_n_next_s = 1'b1;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                busrq_n_next_s = 1'b1;
                busack_next_s  = 1'b0;
            end
        endcase
        owner_next_s = (state_next_s == ST_GRANT) || (state_next_s == ST_DRAIN);
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            busrq_n_r <= 1'b1;
            busack_r  <= 1'b0;
            owner_r   <= 1'b0;
            err_r     <= 1'b0;
            req_cnt_r <= 8'd0;
        end else if (cen) begin
            state_r   <= state_next_s;
            busrq_n_r <= busrq_n_next_s;
            busack_r  <= busack_next_s;
            owner_r   <= owner_next_s;
            err_r     <= err_next_s;
            req_cnt_r <= req_cnt_next_s;
        end
    end

    // Capture read data on the edge that completes a DMA read strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_r <= 8'd0;
        end else if (wait_done_s && dma_memr && !dma_memw) begin
            rdata_r <= mem_rdata;
        end
    end

    // Shared memory port mux; conflicting DMA strobes are suppressed.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        if (owner_r) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_rd    = dma_memr & ~both_s;
            mem_wr    = dma_memw & ~both_s;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_rd    = cpu_rd;
            mem_wr    = cpu_wr;
        end
    end

    assign dma_busack  = busack_r;
    assign dma_ready   = wait_ready_s;
    assign dma_rdata   = rdata_r;
    assign cpu_busrq_n = busrq_n_r;
    assign dma_owner   = owner_r;
    assign timeout_err = err_r;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_dma_bus_arbiter;

    localparam int WS = 2;
    localparam int TO = 255;

    logic        clk;
    logic        rst_n;
    logic        cen;
    logic        dma_busrq;
    logic        dma_busack;
    logic        dma_ready;
    logic        dma_memr;
    logic        dma_memw;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic [7:0]  dma_rdata;
    logic        cpu_busrq_n;
    logic        cpu_busack_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_rdata;
    logic        dma_owner;
    logic        timeout_err;

    int n_cmp;
    int n_bad;

    // Reference model: phase 0 = CPU owns bus, 1 = waiting for CPU release,
    // 2 = DMA owns bus, 3 = DMA releasing bus.
    int         m_ph;
    int         m_reqc;
    int         m_wait;
    bit         m_prev;
    logic       m_busrq_n;
    logic       m_busack;
    logic       m_ready;
    logic       m_err;
    logic [7:0] m_rdata;

    dma_bus_arbiter #(
        .WAIT_STATES (WS),
        .REQ_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cen          (cen),
        .dma_busrq    (dma_busrq),
        .dma_busack   (dma_busack),
        .dma_ready    (dma_ready),
        .dma_memr     (dma_memr),
        .dma_memw     (dma_memw),
        .dma_addr     (dma_addr),
        .dma_wdata    (dma_wdata),
        .dma_rdata    (dma_rdata),
        .cpu_busrq_n  (cpu_busrq_n),
        .cpu_busack_n (cpu_busack_n),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rd       (cpu_rd),
        .cpu_wr       (cpu_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_rdata    (mem_rdata),
        .dma_owner    (dma_owner),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        int  old_wait;
        bit  strb;
        bit  both;
        if (!rst_n) begin
            m_ph = 0; m_reqc = 0; m_wait = 0; m_prev = 1'b0;
            m_busrq_n = 1'b1; m_busack = 1'b0; m_ready = 1'b1;
            m_err = 1'b0; m_rdata = 8'h00;
            return;
        end
        if (!cen) return;
        old_wait = m_wait;
        both = dma_memr && dma_memw;
        strb = (m_ph == 2) && (dma_memr || dma_memw);
        if (m_wait > 0) begin
            m_wait = m_wait - 1;
            if (m_wait == 0 && dma_memr && !dma_memw) m_rdata = mem_rdata;
        end else if (strb && !m_prev && !both) begin
            m_wait = WS;
            if (WS == 0 && dma_memr) m_rdata = mem_rdata;
        end
        m_prev  = strb;
        m_ready = (m_wait == 0);
        case (m_ph)
            0: if (dma_busrq) begin
                   m_ph = 1; m_busrq_n = 1'b0; m_err = 1'b0; m_reqc = 0;
               end
            1: if (!cpu_busack_n) begin
                   m_ph = 2; m_busack = 1'b1; m_reqc = 0;
               end else if (!dma_busrq) begin
                   m_ph = 0; m_busrq_n = 1'b1; m_reqc = 0;
               end else begin
                   m_reqc = (m_reqc < 255) ? m_reqc + 1 : 255;
                   if (m_reqc >= TO) m_err = 1'b1;
               end
            2: if (!dma_busrq) begin
                   m_ph = 3; m_busack = 1'b0;
               end
            3: if (!dma_memr && !dma_memw && old_wait == 0) begin
                   m_ph = 0; m_busrq_n = 1'b1;
               end
            default: m_ph = 0;
        endcase
    endtask

    // Advance one clock: model follows the active edge, bench returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [12:0] got;
        rst_n = 1'b0; cpu_addr = 16'h1234; cpu_rd = 1'b1; cpu_wr = 1'b0;
        tick();
        got = {cpu_busrq_n, dma_busack, dma_ready, dma_owner, timeout_err, dma_rdata};
        n_cmp++;
        if (got !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_bad++; $display("FAIL reset_outputs got %h expected %h", got, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        end
        n_cmp++;
        if ({mem_addr, mem_rd} !== {16'h1234, 1'b1}) begin
            n_bad++; $display("FAIL reset_mem_mux got %h expected %h", {mem_addr, mem_rd}, {16'h1234, 1'b1});
        end
        rst_n = 1'b1; cpu_rd = 1'b0;
    endtask

    task automatic test_handshake();
        cen = 1'b0; dma_busrq = 1'b1; cpu_busack_n = 1'b1;
        tick();
        n_cmp++;
        if (cpu_busrq_n !== 1'b1) begin
            n_bad++; $display("FAIL cen_hold got %b expected 1", cpu_busrq_n);
        end
        cen = 1'b1;
        tick();
        n_cmp++;
        if ({cpu_busrq_n, dma_busack} !== 2'b00) begin
            n_bad++; $display("FAIL busrq_assert got %b expected 00", {cpu_busrq_n, dma_busack});
        end
        tick(); tick();
        cpu_busack_n = 1'b0;
        #1;
        n_cmp++;
        if (dma_busack !== 1'b0) begin
            n_bad++; $display("FAIL busack_early got %b expected 0", dma_busack);
        end
        tick();
        n_cmp++;
        if ({dma_busack, dma_owner} !== 2'b11) begin
            n_bad++; $display("FAIL grant got %b expected 11", {dma_busack, dma_owner});
        end
    endtask

    task automatic test_wait_read();
        dma_addr = 16'h4000; mem_rdata = 8'hA5; dma_memr = 1'b1;
        #1;
        n_cmp++;
        if ({mem_addr, mem_rd, mem_wr} !== {16'h4000, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL read_mux got %h expected %h", {mem_addr, mem_rd, mem_wr}, {16'h4000, 1'b1, 1'b0});
        end
        tick();
        n_cmp++;
        if (dma_ready !== 1'b0) begin
            n_bad++; $display("FAIL ready_wait1 got %b expected 0", dma_ready);
        end
        tick();
        n_cmp++;
        if (dma_ready !== 1'b0) begin
            n_bad++; $display("FAIL ready_wait2 got %b expected 0", dma_ready);
        end
        tick();
        n_cmp++;
        if ({dma_ready, dma_rdata} !== {1'b1, 8'hA5}) begin
            n_bad++; $display("FAIL read_done got %h expected %h", {dma_ready, dma_rdata}, {1'b1, 8'hA5});
        end
        dma_memr = 1'b0;
        tick();
    endtask

    task automatic test_both_strobes();
        dma_memr = 1'b1; dma_memw = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b1;
        #1;
        n_cmp++;
        if ({mem_rd, mem_wr} !== 2'b00) begin
            n_bad++; $display("FAIL both_strobes got %b expected 00", {mem_rd, mem_wr});
        end
        tick();
        n_cmp++;
        if (dma_ready !== 1'b1) begin
            n_bad++; $display("FAIL both_ready got %b expected 1", dma_ready);
        end
        dma_memr = 1'b0; dma_memw = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        tick();
    endtask

    task automatic test_drain();
        dma_memw = 1'b1; dma_wdata = 8'h3C;
        #1;
        n_cmp++;
        if ({mem_wdata, mem_wr} !== {8'h3C, 1'b1}) begin
            n_bad++; $display("FAIL write_mux got %h expected %h", {mem_wdata, mem_wr}, {8'h3C, 1'b1});
        end
        tick();
        dma_busrq = 1'b0; dma_memw = 1'b0;
        tick();
        n_cmp++;
        if ({dma_busack, dma_owner, dma_ready, cpu_busrq_n} !== 4'b0100) begin
            n_bad++; $display("FAIL drain_enter got %b expected 0100", {dma_busack, dma_owner, dma_ready, cpu_busrq_n});
        end
        tick();
        n_cmp++;
        if ({dma_owner, dma_ready, cpu_busrq_n} !== 3'b110) begin
            n_bad++; $display("FAIL drain_hold got %b expected 110", {dma_owner, dma_ready, cpu_busrq_n});
        end
        tick();
        n_cmp++;
        if ({dma_owner, cpu_busrq_n} !== 2'b01) begin
            n_bad++; $display("FAIL drain_exit got %b expected 01", {dma_owner, cpu_busrq_n});
        end
    endtask

    task automatic test_timeout();
        cpu_busack_n = 1'b1; dma_busrq = 1'b1;
        tick();
        repeat (TO - 1) tick();
        n_cmp++;
        if ({timeout_err, cpu_busrq_n} !== 2'b00) begin
            n_bad++; $display("FAIL timeout_early got %b expected 00", {timeout_err, cpu_busrq_n});
        end
        tick();
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_bad++; $display("FAIL timeout_set got %b expected 1", timeout_err);
        end
        dma_busrq = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if ({cpu_busrq_n, timeout_err, dma_owner} !== 3'b110) begin
            n_bad++; $display("FAIL timeout_sticky got %b expected 110", {cpu_busrq_n, timeout_err, dma_owner});
        end
        dma_busrq = 1'b1;
        tick();
        n_cmp++;
        if ({cpu_busrq_n, timeout_err} !== 2'b00) begin
            n_bad++; $display("FAIL timeout_clear got %b expected 00", {cpu_busrq_n, timeout_err});
        end
        dma_busrq = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        logic [12:0] got;
        dma_busrq = 1'b1; cpu_busack_n = 1'b1;
        tick();
        cpu_busack_n = 1'b0;
        tick();
        dma_memr = 1'b1; dma_addr = 16'h8001;
        tick();
        rst_n = 1'b0; cpu_addr = 16'hBEEF; cpu_rd = 1'b0; cpu_wr = 1'b1;
        tick();
        got = {cpu_busrq_n, dma_busack, dma_ready, dma_owner, timeout_err, dma_rdata};
        n_cmp++;
        if (got !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_bad++; $display("FAIL midreset_outputs got %h expected %h", got, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        end
        n_cmp++;
        if ({mem_addr, mem_rd, mem_wr} !== {16'hBEEF, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL midreset_mem got %h expected %h", {mem_addr, mem_rd, mem_wr}, {16'hBEEF, 1'b0, 1'b1});
        end
        rst_n = 1'b1; dma_busrq = 1'b0; dma_memr = 1'b0; cpu_wr = 1'b0; cpu_busack_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [12:0] got_o;
        logic [12:0] exp_o;
        logic [25:0] got_m;
        logic [25:0] exp_m;
        bit          own;
        bit          both;
        int          sel;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            cen   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) dma_busrq = ~dma_busrq;
            cpu_busack_n = m_busrq_n ? 1'b1 : ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 7);
            dma_memr  = (sel == 1) || (sel == 3) || (sel == 5);
            dma_memw  = (sel == 2) || (sel == 3);
            dma_addr  = 16'($urandom);
            dma_wdata = 8'($urandom);
            cpu_addr  = 16'($urandom);
            cpu_wdata = 8'($urandom);
            cpu_rd    = 1'($urandom);
            cpu_wr    = 1'($urandom);
            mem_rdata = 8'($urandom);
            tick();
            own  = (m_ph == 2) || (m_ph == 3);
            both = dma_memr && dma_memw;
            got_o = {cpu_busrq_n, dma_busack, dma_ready, dma_owner, timeout_err, dma_rdata};
            exp_o = {m_busrq_n, m_busack, m_ready, own, m_err, m_rdata};
            n_cmp++;
            if (got_o !== exp_o) begin
                n_bad++; $display("FAIL rand_outputs cycle %0d got %h expected %h", i, got_o, exp_o);
            end
            got_m = {mem_addr, mem_wdata, mem_rd, mem_wr};
            exp_m = own ? {dma_addr, dma_wdata, dma_memr && !both, dma_memw && !both}
                        : {cpu_addr, cpu_wdata, cpu_rd, cpu_wr};
            n_cmp++;
            if (got_m !== exp_m) begin
                n_bad++; $display("FAIL rand_mem cycle %0d got %h expected %h", i, got_m, exp_m);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; cen = 1'b1; dma_busrq = 1'b0; dma_memr = 1'b0; dma_memw = 1'b0;
        dma_addr = 16'h0000; dma_wdata = 8'h00; cpu_busack_n = 1'b1;
        cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_rd = 1'b0; cpu_wr = 1'b0;
        mem_rdata = 8'h00;
        @(negedge clk);
        test_reset();
        test_handshake();
        test_wait_read();
        test_both_strobes();
        test_drain();
        test_timeout();
        test_reset_mid_transfer();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
